mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported backing memory between the fetch-side instruction port and the memory-stage data port of minuteCore.
- Sits between the core's imem/dmem interfaces and the unified memory model or bus.
- Arbitrates one transaction at a time, with dmem priority and a starvation guard for imem.
- Has a watchdog timeout that completes hung transactions with an error.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive dmem grants allowed while imem waits (1..15)
TIMEOUT, 64, max cycles waiting for mem_ack; 0 disables watchdog

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_rd_addr  in  ADDR_W  fetch address
imem_rd_enable  in  1  fetch request, level, held until imem_rd_ready
imem_rd_data  out  DATA_W  fetch data, valid with imem_rd_ready
imem_rd_ready  out  1  one-cycle completion pulse
imem_err  out  1  one-cycle pulse with imem_rd_ready on timeout
dmem_addr  in  ADDR_W  data address
dmem_r_enable  in  1  load request, level
dmem_w_enable  in  1  store request, level
dmem_w_data  in  DATA_W  store data
dmem_r_data  out  DATA_W  load data, valid with dmem_ready
dmem_ready  out  1  one-cycle completion pulse (loads and stores)
dmem_err  out  1  one-cycle pulse with dmem_ready on timeout
mem_addr  out  ADDR_W  backing address
mem_req  out  1  backing request, held until mem_ack
mem_we  out  1  1 = write
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  backing completion, single cycle

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE.
  - All outputs, starve_cnt and wd_cnt are 0.
  - A reset mid-transaction drops mem_req immediately; the in-flight transaction is abandoned and no ready pulse is issued.
- FSM states: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - Samples requests. imem_pend = imem_rd_enable; dmem_pend = dmem_r_enable | dmem_w_enable.
  - Grant imem if imem_pend and (!dmem_pend or starve_cnt == STARVE_LIMIT); otherwise grant dmem if dmem_pend; otherwise stay in IDLE.
  - On a grant: latch owner, mem_addr, mem_we, mem_wdata; set mem_req=1; go to BUSY.
  - If dmem_w_enable and dmem_r_enable are both 1, the write wins (mem_we=1).
- Starvation counter:
  - dmem grant with imem_pend=1: starve_cnt++ (saturating).
  - Any imem grant, or a dmem grant with imem_pend=0: starve_cnt=0.
- BUSY:
  - mem_req, mem_addr, mem_we, mem_wdata are held stable; wd_cnt increments each cycle.
  - On mem_ack: capture mem_rdata into the owner's data register (loads and fetches only); mem_req=0; go to RESP.
  - If TIMEOUT != 0 and wd_cnt == TIMEOUT-1 without mem_ack: mem_req=0, owner data=0, set err flag, go to RESP.
  - A late mem_ack after a timeout abort is ignored (owner of the backing side must tolerate the abort).
- RESP:
  - Exactly one cycle; the owner's ready=1, plus err if flagged.
  - Clear wd_cnt; go to IDLE.
  - Requests are not sampled in RESP, which gives the requester one edge to drop or advance its request.
- Data outputs:
  - imem_rd_data/dmem_r_data hold their last value until the next completion for that port.
  - A store completion leaves dmem_r_data unchanged.
- Latency: request seen in IDLE at cycle 0 → mem_req in cycle 1 → with zero-wait ack in cycle 1, ready in cycle 2 → IDLE in cycle 3. Throughput is one transaction per 3 cycles minimum.
- Requester deasserting its enable during BUSY: the transaction still completes and the ready pulse is still issued; the requester must ignore it.
- Requests are level-sensitive; no queuing beyond the one in-flight transaction.

Decomposition:
- Shared package/def_params: FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), owner encoding (OWN_IMEM=1'b0, OWN_DMEM=1'b1), default widths.
- One natural sub-module: mem_arb_watchdog, containing wd_cnt, TIMEOUT compare, and the expire/clear interface.
- Arbitration decision and FSM stay in the top module.

Test Plan:
- imem-only read, addr 0x100, mem_ack in the first BUSY cycle, mem_rdata=0xDEADBEEF → imem_rd_ready and imem_rd_data=0xDEADBEEF exactly 2 cycles after the request is sampled; dmem_ready stays 0.
- Simultaneous imem (0x200) and dmem store (0x300, 0x12345678) → dmem granted first (mem_we=1, mem_addr=0x300), dmem_ready pulses; imem is served next.
- imem held and dmem continuously re-requesting, STARVE_LIMIT=4 → exactly 4 dmem grants, then an imem grant; starve_cnt returns to 0.
- mem_ack withheld, TIMEOUT=64 → mem_req drops after 64 BUSY cycles; dmem_ready=1, dmem_err=1, dmem_r_data=0 for one cycle; a subsequent request is served normally.
- reset driven low in the middle of BUSY → mem_req=0 immediately, no ready pulse; after release, IDLE with all outputs 0.
- dmem_r_enable and dmem_w_enable both 1 → mem_we=1 (write wins); dmem_r_data is unchanged after dmem_ready.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the minuteCore instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Wide enough for the largest starvation limit (15).
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  // Width of the watchdog counter: it only has to reach TIMEOUT-1.
  function automatic int wd_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Counts cycles spent waiting for the backing memory and flags expiry.
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic run_i,     // a transaction is waiting for mem_ack this cycle
  input  logic clr_i,     // transaction finished, restart the count
  output logic expire_o   // this is the last allowed waiting cycle
);

  localparam int                WD_W    = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  // Next count: clear on completion, advance while waiting.
  always_comb begin
    // NOTE: assign a default first so every path drives the signal and no latch is inferred.
    wd_cnt_d = wd_cnt_q;
    if (clr_i) begin
      wd_cnt_d = '0;
    end else if (run_i) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // A zero TIMEOUT disables the watchdog entirely.
  assign expire_o = (TIMEOUT != 0) && run_i && (wd_cnt_q == WD_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch port and the data port onto one single-ported backing
// memory. One transaction in flight; dmem has priority, imem is protected from
// starvation, and a watchdog completes hung transactions with an error.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic [ADDR_W-1:0] imem_rd_addr,
  input  logic              imem_rd_enable,
  output logic [DATA_W-1:0] imem_rd_data,
  output logic              imem_rd_ready,
  output logic              imem_err,
  // data port
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_r_enable,
  input  logic              dmem_w_enable,
  input  logic [DATA_W-1:0] dmem_w_data,
  output logic [DATA_W-1:0] dmem_r_data,
  output logic              dmem_ready,
  output logic              dmem_err,
  // backing memory
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_SAT = '1;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   imem_rd_data_q, imem_rd_data_d;
  logic                imem_rd_ready_q, imem_rd_ready_d;
  logic                imem_err_q, imem_err_d;
  logic [DATA_W-1:0]   dmem_r_data_q, dmem_r_data_d;
  logic                dmem_ready_q, dmem_ready_d;
  logic                dmem_err_q, dmem_err_d;

  logic imem_pend, dmem_pend, grant_imem, grant_dmem;
  logic wd_expire;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .run_i    (state_q == ST_BUSY),
    .clr_i    (state_q == ST_RESP),
    .expire_o (wd_expire)
  );

  // Arbitration: dmem wins unless imem has waited through STARVE_LIMIT dmem grants.
  always_comb begin
    imem_pend  = imem_rd_enable;
    dmem_pend  = dmem_r_enable | dmem_w_enable;
    grant_imem = imem_pend && (!dmem_pend || (starve_cnt_q == STARVE_MAX));
    grant_dmem = dmem_pend && !grant_imem;
  end

  // Next-state and next-output computation for the IDLE/BUSY/RESP sequence.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    starve_cnt_d    = starve_cnt_q;
    mem_addr_d      = mem_addr_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_wdata_d     = mem_wdata_q;
    imem_rd_data_d  = imem_rd_data_q;
    dmem_r_data_d   = dmem_r_data_q;
    // Completion strobes are single-cycle pulses.
    imem_rd_ready_d = 1'b0;
    imem_err_d      = 1'b0;
    dmem_ready_d    = 1'b0;
    dmem_err_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_imem) begin
          owner_d      = OWN_IMEM;
          mem_addr_d   = imem_rd_addr;
          mem_we_d     = 1'b0;
          mem_wdata_d  = dmem_w_data;
          mem_req_d    = 1'b1;
          starve_cnt_d = '0;
          state_d      = ST_BUSY;
        end else if (grant_dmem) begin
          owner_d      = OWN_DMEM;
          mem_addr_d   = dmem_addr;
          // A simultaneous read and write request is treated as a write.
          mem_we_d     = dmem_w_enable;
          mem_wdata_d  = dmem_w_data;
          mem_req_d    = 1'b1;
          if (imem_pend) begin
            starve_cnt_d = (starve_cnt_q == STARVE_SAT) ? starve_cnt_q
                                                        : starve_cnt_q + STARVE_W'(1);
          end else begin
            starve_cnt_d = '0;
          end
          state_d      = ST_BUSY;
        end
      end

      ST_BUSY: begin
        // A real acknowledge takes precedence over expiry in the same cycle.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (owner_q == OWN_IMEM) begin
            imem_rd_data_d  = mem_rdata;
            imem_rd_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              dmem_r_data_d = mem_rdata;
            end
            dmem_ready_d = 1'b1;
          end
        end else if (wd_expire) begin
          // Abort: the owner gets zero data with an error flag.
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (owner_q == OWN_IMEM) begin
            imem_rd_data_d  = '0;
            imem_rd_ready_d = 1'b1;
            imem_err_d      = 1'b1;
          end else begin
            dmem_r_data_d = '0;
            dmem_ready_d  = 1'b1;
            dmem_err_d    = 1'b1;
          end
        end
      end

      ST_RESP: begin
        // Requests are not sampled here so the requester can drop or advance them.
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FSM and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      owner_q         <= OWN_IMEM;
      starve_cnt_q    <= '0;
      mem_addr_q      <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_wdata_q     <= '0;
      imem_rd_data_q  <= '0;
      imem_rd_ready_q <= 1'b0;
      imem_err_q      <= 1'b0;
      dmem_r_data_q   <= '0;
      dmem_ready_q    <= 1'b0;
      dmem_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      starve_cnt_q    <= starve_cnt_d;
      mem_addr_q      <= mem_addr_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_wdata_q     <= mem_wdata_d;
      imem_rd_data_q  <= imem_rd_data_d;
      imem_rd_ready_q <= imem_rd_ready_d;
      imem_err_q      <= imem_err_d;
      dmem_r_data_q   <= dmem_r_data_d;
      dmem_ready_q    <= dmem_ready_d;
      dmem_err_q      <= dmem_err_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign imem_rd_data  = imem_rd_data_q;
  assign imem_rd_ready = imem_rd_ready_q;
  assign imem_err      = imem_err_q;
  assign dmem_r_data   = dmem_r_data_q;
  assign dmem_ready    = dmem_ready_q;
  assign dmem_err      = dmem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected responses,
// a negedge monitor predicts grants from the arbitration rules and checks
// every completion against the queued expectations.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] imem_rd_addr;
  logic          imem_rd_enable;
  logic [DW-1:0] imem_rd_data;
  logic          imem_rd_ready;
  logic          imem_err;
  logic [AW-1:0] dmem_addr;
  logic          dmem_r_enable;
  logic          dmem_w_enable;
  logic [DW-1:0] dmem_w_data;
  logic [DW-1:0] dmem_r_data;
  logic          dmem_ready;
  logic          dmem_err;
  logic [AW-1:0] mem_addr;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          resp_ack;
  logic          late_ack;

  assign mem_ack = resp_ack | late_ack;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_rd_addr(imem_rd_addr), .imem_rd_enable(imem_rd_enable),
    .imem_rd_data(imem_rd_data), .imem_rd_ready(imem_rd_ready), .imem_err(imem_err),
    .dmem_addr(dmem_addr), .dmem_r_enable(dmem_r_enable), .dmem_w_enable(dmem_w_enable),
    .dmem_w_data(dmem_w_data), .dmem_r_data(dmem_r_data), .dmem_ready(dmem_ready),
    .dmem_err(dmem_err),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t imem_q[$];
  exp_t dmem_q[$];
  bit   owner_q[$];     // 0 = imem completion expected next, 1 = dmem

  int n_cmp = 0;
  int n_bad = 0;
  bit withhold = 1'b0;  // backing memory never acknowledges while set
  int fixed_delay = 0;  // <0 selects a random ack delay
  int cur_delay = 0;
  int dmem_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Contents of the backing memory as seen by reads.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Backing memory: acks after cur_delay waiting cycles (0 = first BUSY cycle).
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    resp_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (!reset || !mem_req) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0)
          cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
        if (!withhold && wait_cnt == cur_delay) begin
          resp_ack  = 1'b1;
          mem_rdata = mem_we ? $urandom : rd_val(mem_addr);
        end
        wait_cnt++;
      end
    end
  end

  // Monitor: predicts each grant, checks the backing request and every completion.
  initial begin : monitor
    logic p_ie, p_dr, p_dw, p_req;
    logic [31:0] p_ia, p_da, p_dwd, last_i, last_d, g_addr;
    int starve, req_len;
    bit exp_own, own;
    exp_t e;
    p_ie = 0; p_dr = 0; p_dw = 0; p_req = 0;
    p_ia = 0; p_da = 0; p_dwd = 0; last_i = 0; last_d = 0; g_addr = 0;
    starve = 0; req_len = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        starve = 0; req_len = 0;
        owner_q.delete(); imem_q.delete(); dmem_q.delete();
        last_i = 0; last_d = 0;
      end else begin
        // New grant: inputs seen at the previous negedge were sampled in IDLE.
        if (mem_req && !p_req) begin
          if (!(p_ie || p_dr || p_dw)) check("grant_without_request", 1, 0);
          exp_own = !(p_ie && (!(p_dr || p_dw) || starve == SL));
          if (!exp_own) begin
            g_addr = p_ia;
            check("grant_imem_addr", mem_addr, p_ia);
            check("grant_imem_we", mem_we, 0);
            starve = 0;
          end else begin
            g_addr = p_da;
            check("grant_dmem_addr", mem_addr, p_da);
            check("grant_dmem_we", mem_we, p_dw);
            if (p_dw) check("grant_dmem_wdata", mem_wdata, p_dwd);
            starve = p_ie ? ((starve < 15) ? starve + 1 : 15) : 0;
          end
          owner_q.push_back(exp_own);
        end else if (mem_req && p_req) begin
          check("mem_addr_stable", mem_addr, g_addr);
        end
        if (mem_req) req_len++;
        else if (p_req) begin
          check("mem_req_cycles", req_len, withhold ? TO : cur_delay + 1);
          req_len = 0;
        end

        // Completions.
        if (imem_rd_ready || dmem_ready) begin
          if (imem_rd_ready && dmem_ready) check("both_ready", 1, 0);
          if (owner_q.size() == 0) begin
            check("unexpected_ready", 1, 0);
          end else begin
            own = owner_q.pop_front();
            check("ready_port_is_dmem", dmem_ready, own);
            if (!own) begin
              if (imem_q.size() == 0) check("imem_queue_empty", 1, 0);
              else begin
                e = imem_q.pop_front();
                check("imem_rd_data", imem_rd_data, e.data);
                check("imem_err", imem_err, e.err);
                last_i = e.data;
              end
            end else begin
              if (dmem_q.size() == 0) check("dmem_queue_empty", 1, 0);
              else begin
                e = dmem_q.pop_front();
                if (e.we && !e.err) check("dmem_r_data_after_store", dmem_r_data, last_d);
                else begin
                  check("dmem_r_data", dmem_r_data, e.data);
                  last_d = e.data;
                end
                check("dmem_err", dmem_err, e.err);
              end
            end
          end
        end
        if (!imem_rd_ready) check("imem_rd_data_hold", imem_rd_data, last_i);
        if (!dmem_ready) check("dmem_r_data_hold", dmem_r_data, last_d);
        if ((imem_err && !imem_rd_ready) || (dmem_err && !dmem_ready))
          check("err_without_ready", 1, 0);
      end
      p_ie = imem_rd_enable; p_ia = imem_rd_addr;
      p_dr = dmem_r_enable; p_dw = dmem_w_enable; p_da = dmem_addr; p_dwd = dmem_w_data;
      p_req = mem_req;
    end
  end

  task automatic do_imem(input logic [31:0] a, input bit err, output int lat);
    exp_t e;
    e.addr = a; e.we = 1'b0; e.err = err;
    e.data = err ? 32'h0 : rd_val(a);
    imem_q.push_back(e);
    imem_rd_addr = a;
    imem_rd_enable = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (imem_rd_ready) break;
      lat++;
      if (lat > 300) begin check("imem_ready_timeout", 0, 1); break; end
    end
    @(posedge clk);
    #1;
    imem_rd_enable = 1'b0;
    imem_rd_addr = $urandom;
  endtask

  task automatic do_dmem(input logic [31:0] a, input bit re, input bit we,
                         input logic [31:0] wd, input bit err);
    exp_t e;
    int n;
    e.addr = a; e.we = we; e.err = err;
    e.data = (err || we) ? 32'h0 : rd_val(a);
    dmem_q.push_back(e);
    dmem_addr = a;
    dmem_r_enable = re;
    dmem_w_enable = we;
    dmem_w_data = wd;
    n = 0;
    forever begin
      @(negedge clk);
      if (dmem_ready) break;
      n++;
      if (n > 300) begin check("dmem_ready_timeout", 0, 1); break; end
    end
    @(posedge clk);
    #1;
    dmem_r_enable = 1'b0;
    dmem_w_enable = 1'b0;
    dmem_w_data = $urandom;
    dmem_addr = $urandom;
    dmem_done++;
  endtask

  initial begin : global_timeout
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin : main
    int lat, seen, n;
    imem_rd_addr = '0; imem_rd_enable = 1'b0;
    dmem_addr = '0; dmem_r_enable = 1'b0; dmem_w_enable = 1'b0; dmem_w_data = '0;
    late_ack = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_imem_ready", imem_rd_ready, 0);
    check("rst_dmem_ready", dmem_ready, 0);
    check("rst_imem_data", imem_rd_data, 0);
    check("rst_dmem_data", dmem_r_data, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Fetch alone with a zero-wait ack: ready two cycles after sampling.
    fixed_delay = 0;
    do_imem(32'h100, 1'b0, lat);
    check("imem_latency", lat, 2);

    // Simultaneous fetch and store: store first, fetch next.
    fork
      do_imem(32'h200, 1'b0, lat);
      do_dmem(32'h300, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    join

    // Starvation guard: four dmem grants, then the waiting fetch.
    fixed_delay = -1;
    dmem_done = 0;
    fork
      begin
        do_imem(32'h204, 1'b0, lat);
        seen = dmem_done;
      end
      for (int i = 0; i < 6; i++)
        do_dmem(32'h2000 + 32'(i * 4), 1'b1, 1'b0, 32'h0, 1'b0);
    join
    check("dmem_grants_before_imem", seen, SL);

    // Watchdog abort on a load, a late ack that must be ignored, then normal service.
    withhold = 1'b1;
    do_dmem(32'h400, 1'b1, 1'b0, 32'h0, 1'b1);
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    withhold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_dmem(32'h404, 1'b1, 1'b0, 32'h0, 1'b0);
    withhold = 1'b1;
    do_imem(32'h108, 1'b1, lat);
    withhold = 1'b0;

    // Read and write together: the write wins and load data is untouched.
    do_dmem(32'h500, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0);

    // Random traffic from both ports.
    fork
      for (int i = 0; i < 40; i++) begin
        int g;
        g = $urandom_range(0, 3);
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
        do_imem(32'h100 + 32'($urandom_range(0, 63) * 4), 1'b0, lat);
      end
      for (int i = 0; i < 40; i++) begin
        int g, k;
        g = $urandom_range(0, 3);
        k = $urandom_range(0, 2);
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
        do_dmem(32'h2000 + 32'($urandom_range(0, 255) * 4), k != 1, k != 0, $urandom, 1'b0);
      end
    join

    // Reset in the middle of a transaction.
    withhold = 1'b1;
    dmem_addr = 32'h600;
    dmem_r_enable = 1'b1;
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    check("reset_test_mem_req_seen", mem_req, 1);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_mem_req", mem_req, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_we", mem_we, 0);
    check("midrst_dmem_ready", dmem_ready, 0);
    check("midrst_dmem_data", dmem_r_data, 0);
    check("midrst_imem_data", imem_rd_data, 0);
    dmem_r_enable = 1'b0;
    withhold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_ready", {imem_rd_ready, dmem_ready, mem_req}, 0);
    end
    @(posedge clk);
    #1;
    do_imem(32'h10C, 1'b0, lat);
    repeat (4) @(posedge clk);
    check("scoreboard_drained", owner_q.size() + imem_q.size() + dmem_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
